axis_quadrature_tracker: RTL and testbench

AXIS_QUADRATURE_TRACKER -- requirements
Module: axis_quadrature_tracker

---
 rtl/axis_quadrature_tracker_pkg.sv | 37 +++
 rtl/axis_quadrature_tracker_schmitt_trigger.sv | 46 ++++
 rtl/axis_quadrature_tracker.sv | 130 +++++++++++++
 tb/tb_axis_quadrature_tracker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_quadrature_tracker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_quadrature_tracker_pkg                                  |
// | Description : Quadrature state encodings and step-direction decoding.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package axis_quadrature_tracker_pkg;

  // Quadrature state {B,A}, listed in forward order.
  localparam logic [1:0] Q_00 = 2'b00;
  localparam logic [1:0] Q_01 = 2'b01;
  localparam logic [1:0] Q_11 = 2'b11;
  localparam logic [1:0] Q_10 = 2'b10;

  localparam logic [1:0] DIR_HOLD    = 2'd0;
  localparam logic [1:0] DIR_FWD     = 2'd1;
  localparam logic [1:0] DIR_REV     = 2'd2;
  localparam logic [1:0] DIR_ILLEGAL = 2'd3;

  function automatic logic [1:0] quad_fwd_next(input logic [1:0] q);
    case (q)
      Q_00:    return Q_01;
      Q_01:    return Q_11;
      Q_11:    return Q_10;
      default: return Q_00;
    endcase
  endfunction

  function automatic logic [1:0] quad_dir(input logic [1:0] prev, input logic [1:0] nxt);
    if (prev == nxt)                     return DIR_HOLD;
    else if (nxt == quad_fwd_next(prev)) return DIR_FWD;
    else if (prev == quad_fwd_next(nxt)) return DIR_REV;
    else                                 return DIR_ILLEGAL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_quadrature_tracker_schmitt_trigger.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : schmitt_trigger                                              |
// | Description : Signed hysteresis comparator, state advances when enabled.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module schmitt_trigger #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  input  logic signed [DATA_WIDTH-1:0] i_lower,
  input  logic signed [DATA_WIDTH-1:0] i_upper,
  output logic                         o_bit,
  output logic                         o_bit_next
);

  logic r_bit;
  logic w_above;
  logic w_below;

  assign w_above = (i_data > i_upper);
  assign w_below = (i_data < i_lower);

  // Both conditions true only with inverted thresholds; hold in that case.
  always_comb begin
    o_bit_next = r_bit;
    if (w_above && !w_below)
      o_bit_next = 1'b1;
    else if (w_below && !w_above)
      o_bit_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_bit <= 1'b0;
    else if (i_en)
      r_bit <= o_bit_next;
  end

  assign o_bit = r_bit;

endmodule
`default_nettype wire

// File: rtl/axis_quadrature_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_quadrature_tracker                                      |
// | Description : AXI-Stream A/B quadrature decoder with signed position out.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module axis_quadrature_tracker
  import axis_quadrature_tracker_pkg::*;
#(
  parameter int S_AXIS_TDATA_WIDTH = 32,
  parameter int M_AXIS_TDATA_WIDTH = 32,
  parameter int ERR_WIDTH          = 16
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic signed [S_AXIS_TDATA_WIDTH/2-1:0] FC_lower_threshold,
  input  logic signed [S_AXIS_TDATA_WIDTH/2-1:0] FC_upper_threshold,
  input  logic [4:0]                           FC_log_scale,
  input  logic                                 FC_saturate,
  input  logic                                 FC_clear,
  input  logic                                 S_AXIS_tvalid,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]        S_AXIS_tdata,
  output logic                                 S_AXIS_tready,
  input  logic                                 M_AXIS_tready,
  output logic                                 M_AXIS_tvalid,
  output logic [M_AXIS_TDATA_WIDTH-1:0]        M_AXIS_tdata,
  output logic [ERR_WIDTH-1:0]                 error_count
);

  localparam int HW     = S_AXIS_TDATA_WIDTH / 2;
  localparam int PW     = M_AXIS_TDATA_WIDTH;
  localparam int MAX_SH = PW - 2;
  localparam logic [PW:0]          C_ONE     = {{PW{1'b0}}, 1'b1};
  localparam logic [ERR_WIDTH-1:0] C_ERR_ONE = {{(ERR_WIDTH-1){1'b0}}, 1'b1};

  logic                 w_accept;
  logic                 r_tvalid;
  logic [PW-1:0]        r_pos;
  logic [PW-1:0]        r_tdata;
  logic [ERR_WIDTH-1:0] r_err;
  logic                 w_a, w_b, w_a_nxt, w_b_nxt;
  logic [1:0]           w_dir;
  logic [PW:0]          w_step, w_ext, w_sum;
  logic [PW-1:0]        w_stepped, w_pos_nxt;
  logic [ERR_WIDTH-1:0] w_err_nxt;

  assign S_AXIS_tready = ~r_tvalid | M_AXIS_tready;
  assign w_accept      = S_AXIS_tvalid & S_AXIS_tready;

  schmitt_trigger #(.DATA_WIDTH(HW)) u_schmitt_a (
    .clk        (aclk),
    .rst_n      (aresetn),
    .i_en       (w_accept),
    .i_data     (S_AXIS_tdata[HW-1:0]),
    .i_lower    (FC_lower_threshold),
    .i_upper    (FC_upper_threshold),
    .o_bit      (w_a),
    .o_bit_next (w_a_nxt)
  );

  schmitt_trigger #(.DATA_WIDTH(HW)) u_schmitt_b (
    .clk        (aclk),
    .rst_n      (aresetn),
    .i_en       (w_accept),
    .i_data     (S_AXIS_tdata[S_AXIS_TDATA_WIDTH-1:HW]),
    .i_lower    (FC_lower_threshold),
    .i_upper    (FC_upper_threshold),
    .o_bit      (w_b),
    .o_bit_next (w_b_nxt)
  );

  assign w_dir = quad_dir({w_b, w_a}, {w_b_nxt, w_a_nxt});

  // Step is capped so it always fits as a positive value in the position.
  always_comb begin
    if (int'(FC_log_scale) > MAX_SH)
      w_step = C_ONE << MAX_SH;
    else
      w_step = C_ONE << FC_log_scale;
  end

  // One guard bit exposes signed overflow of the step.
  assign w_ext = {r_pos[PW-1], r_pos};
  assign w_sum = (w_dir == DIR_REV) ? (w_ext - w_step) : (w_ext + w_step);

  always_comb begin
    w_stepped = w_sum[PW-1:0];
    if (FC_saturate && (w_sum[PW] != w_sum[PW-1]))
      w_stepped = w_sum[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
  end

  always_comb begin
    w_pos_nxt = r_pos;
    w_err_nxt = r_err;
    if (w_accept) begin
      if (w_dir == DIR_FWD || w_dir == DIR_REV)
        w_pos_nxt = w_stepped;
      else if (w_dir == DIR_ILLEGAL && !(&r_err))
        w_err_nxt = r_err + C_ERR_ONE;
    end
    if (FC_clear) begin
      w_pos_nxt = '0;
      w_err_nxt = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pos    <= '0;
      r_err    <= '0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
    end else begin
      r_pos <= w_pos_nxt;
      r_err <= w_err_nxt;
      if (w_accept) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_pos_nxt;
      end else if (M_AXIS_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign M_AXIS_tvalid = r_tvalid;
  assign M_AXIS_tdata  = r_tdata;
  assign error_count   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axis_quadrature_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axis_quadrature_tracker                                   |
// | Description : Directed self-checking bench, 32-bit and 8-bit positions.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_axis_quadrature_tracker;

  localparam logic signed [15:0] HI = 16'sd200;
  localparam logic signed [15:0] LO = -16'sd200;

  logic               aclk = 1'b0;
  logic               aresetn;
  logic signed [15:0] fc_lower, fc_upper;
  logic [4:0]         fc_scale;
  logic               fc_sat, fc_clear;
  logic               s_tvalid;
  logic [31:0]        s_tdata;
  logic               s_tready, s8_tready;
  logic               m_tready;
  logic               m_tvalid, m8_tvalid;
  logic signed [31:0] m_tdata;
  logic signed [7:0]  m8_tdata;
  logic [15:0]        err, err8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 aclk = ~aclk;

  axis_quadrature_tracker #(.S_AXIS_TDATA_WIDTH(32), .M_AXIS_TDATA_WIDTH(32), .ERR_WIDTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .FC_lower_threshold(fc_lower), .FC_upper_threshold(fc_upper),
    .FC_log_scale(fc_scale), .FC_saturate(fc_sat), .FC_clear(fc_clear),
    .S_AXIS_tvalid(s_tvalid), .S_AXIS_tdata(s_tdata), .S_AXIS_tready(s_tready),
    .M_AXIS_tready(m_tready), .M_AXIS_tvalid(m_tvalid), .M_AXIS_tdata(m_tdata),
    .error_count(err)
  );

  axis_quadrature_tracker #(.S_AXIS_TDATA_WIDTH(32), .M_AXIS_TDATA_WIDTH(8), .ERR_WIDTH(16)) dut8 (
    .aclk(aclk), .aresetn(aresetn),
    .FC_lower_threshold(fc_lower), .FC_upper_threshold(fc_upper),
    .FC_log_scale(fc_scale), .FC_saturate(fc_sat), .FC_clear(fc_clear),
    .S_AXIS_tvalid(s_tvalid), .S_AXIS_tdata(s_tdata), .S_AXIS_tready(s8_tready),
    .M_AXIS_tready(m_tready), .M_AXIS_tvalid(m8_tvalid), .M_AXIS_tdata(m8_tdata),
    .error_count(err8)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One beat {B,A}; returns at the negedge after acceptance.
  task automatic send(input logic signed [15:0] a, input logic signed [15:0] b);
    int cnt = 0;
    @(negedge aclk);
    s_tdata  = {b, a};
    s_tvalid = 1'b1;
    while (!s_tready && cnt < 20) begin
      @(negedge aclk);
      cnt++;
    end
    if (!s_tready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got tready 0, expected 1");
    end
    @(posedge aclk);
    @(negedge aclk);
    s_tvalid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge aclk);
    fc_clear = 1'b1;
    @(negedge aclk);
    fc_clear = 1'b0;
  endtask

  task automatic fwd_cycle();
    send(HI, LO); send(HI, HI); send(LO, HI); send(LO, LO);
  endtask

  task automatic rev_cycle();
    send(LO, HI); send(HI, HI); send(HI, LO); send(LO, LO);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0; fc_lower = -16'sd100; fc_upper = 16'sd100;
    fc_scale = 5'd0; fc_sat = 1'b0; fc_clear = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_err", err, 0);
    chk("rst_s_tready", s_tready, 1);
    aresetn = 1'b1;

    // Forward counting, unit step
    for (int i = 0; i < 8; i++) fwd_cycle();
    chk("fwd8_pos", m_tdata, 32);
    chk("fwd8_err", err, 0);

    // Reverse counting, step 16
    do_clear();
    fc_scale = 5'd4;
    for (int i = 0; i < 8; i++) rev_cycle();
    chk("rev8_pos", m_tdata, -512);
    for (int i = 0; i < 3; i++) begin
      send(-16'sd50, LO);
      send(16'sd50, LO);
    end
    chk("osc_pos", m_tdata, -512);
    send(16'sd100, LO);
    chk("at_upper_hold", m_tdata, -512);
    fc_lower = 16'sd100; fc_upper = -16'sd100;
    send(16'sd0, LO);
    chk("inverted_thr_hold", m_tdata, -512);
    fc_lower = -16'sd100; fc_upper = 16'sd100;

    // Illegal double-bit jumps
    fc_scale = 5'd0;
    send(HI, HI);
    chk("jump1_pos", m_tdata, -512);
    send(LO, HI); send(LO, LO);
    chk("ret1_pos", m_tdata, -510);
    send(HI, HI);
    chk("jump2_pos", m_tdata, -510);
    send(HI, LO); send(LO, LO);
    send(HI, HI);
    chk("jump3_pos", m_tdata, -512);
    chk("jump3_err", err, 3);
    send(LO, HI); send(LO, LO);
    chk("after_jumps_pos", m_tdata, -510);
    chk("after_jumps_err", err, 3);

    // 8-bit saturation and wrap
    do_clear();
    fc_sat = 1'b1;
    fc_scale = 5'd6; send(HI, LO);
    fc_scale = 5'd5; send(HI, HI);
    fc_scale = 5'd4; send(LO, HI);
    fc_scale = 5'd3; send(LO, LO);
    chk("w8_build_120", m8_tdata, 120);
    fc_scale = 5'd4; send(HI, LO);
    chk("w8_sat_127", m8_tdata, 127);
    chk("w32_no_sat_136", m_tdata, 136);
    do_clear();
    fc_scale = 5'd6; send(HI, HI);
    fc_scale = 5'd5; send(LO, HI);
    fc_scale = 5'd4; send(LO, LO);
    fc_scale = 5'd3; send(HI, LO);
    fc_sat = 1'b0;
    fc_scale = 5'd4; send(HI, HI);
    chk("w8_wrap_m120", m8_tdata, -120);
    do_clear();
    fc_scale = 5'd31; send(LO, HI);
    chk("w8_scale_cap", m8_tdata, 64);
    chk("w32_scale_cap", m_tdata, 1073741824);
    fc_scale = 5'd0; send(LO, LO);

    // Output backpressure
    do_clear();
    @(negedge aclk);
    m_tready = 1'b0;
    s_tdata = {LO, HI}; s_tvalid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    s_tdata = {HI, HI};
    for (int i = 0; i < 5; i++) begin
      chk("bp_s_tready", s_tready, 0);
      chk("bp_m_tvalid", m_tvalid, 1);
      chk("bp_m_tdata", m_tdata, 1);
      @(negedge aclk);
    end
    m_tready = 1'b1;
    @(posedge aclk);
    #1;
    chk("bp_release_tdata", m_tdata, 2);
    chk("bp_release_tvalid", m_tvalid, 1);
    @(negedge aclk);
    s_tvalid = 1'b0;

    // Clear coincident with a forward step
    @(negedge aclk);
    fc_clear = 1'b1; s_tdata = {HI, LO}; s_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    chk("clear_step_pos", m_tdata, 0);
    chk("clear_step_err", err, 0);
    @(negedge aclk);
    fc_clear = 1'b0; s_tvalid = 1'b0;
    send(LO, LO);
    chk("after_clear_step", m_tdata, 1);

    // Reset mid-stream with a pending beat
    send(HI, HI); send(LO, LO);
    chk("pre_rst_err", err, 2);
    @(negedge aclk);
    m_tready = 1'b0;
    send(HI, LO);
    chk("pre_rst_pending", m_tvalid, 1);
    chk("pre_rst_tdata", m_tdata, 2);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_tvalid", m_tvalid, 0);
    chk("mid_rst_tdata", m_tdata, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_s_tready", s_tready, 1);
    @(negedge aclk);
    aresetn = 1'b1; m_tready = 1'b1;
    send(HI, LO);
    chk("post_rst_first_beat", m_tdata, 1);
    chk("post_rst_err", err, 0);

    repeat (2) @(negedge aclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
